// File: rtl/cram_async_ctrlr_if.sv
// Application-side handshake bundle between the top-level sequencers and the
// asynchronous Cellular RAM controller.
// Optional feature macro: CRAM_BYTE_MASK_EN adds the app_be byte-enable pair.
interface cram_async_ctrlr_if;
  logic [22:0] app_addr;
  logic [15:0] app_data_in;
  logic        app_wr;
  logic        app_rd;
`ifdef CRAM_BYTE_MASK_EN
  logic [1:0]  app_be;
`endif
  logic [15:0] app_data_out;
  logic        app_data_ok;
  logic        app_op_begun;
  logic        op_finished;
  logic        app_ctrlr_good;

  // Sequencer side: issues requests, observes completion.
  modport master (
`ifdef CRAM_BYTE_MASK_EN
    output app_be,
`endif
    output app_addr, app_data_in, app_wr, app_rd,
    input  app_data_out, app_data_ok, app_op_begun, op_finished, app_ctrlr_good
  );

  // Controller side: accepts requests, reports completion.
  modport slave (
`ifdef CRAM_BYTE_MASK_EN
    input  app_be,
`endif
    input  app_addr, app_data_in, app_wr, app_rd,
    output app_data_out, app_data_ok, app_op_begun, op_finished, app_ctrlr_good
  );
endinterface

// File: rtl/cram_async_ctrlr.sv
// Asynchronous-mode Cellular RAM (PSRAM) controller. Waits out the power-up
// interval, then serves single-word reads/writes with CE#/OE#/WE# pulse widths
// set by a cycle counter. Every pin and handshake output is a flop so the
// asynchronous PSRAM timing edges are glitch-free.
// Optional feature macro: CRAM_BYTE_MASK_EN (per-byte write enables via app_be).
module cram_async_ctrlr #(
  parameter int PWRUP_CYCLES = 15000,
  parameter int RD_CYCLES    = 8,
  parameter int WR_CYCLES    = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  cram_async_ctrlr_if.slave  app,
  output logic [22:0]        mem_addr,
  output logic               mem_clk,
  output logic               mem_ce_n,
  output logic               mem_oe_n,
  output logic               mem_we_n,
  output logic               mem_adv_n,
  output logic               mem_ub_n,
  output logic               mem_lb_n,
  output logic               mem_cre,
  inout  wire  [15:0]        mem_data
);

  localparam int PW_W = (PWRUP_CYCLES < 2) ? 1 : $clog2(PWRUP_CYCLES);
  localparam int RD_W = (RD_CYCLES < 2) ? 1 : $clog2(RD_CYCLES);
  localparam int WR_W = (WR_CYCLES < 2) ? 1 : $clog2(WR_CYCLES);
  localparam int OP_W = (RD_W > WR_W) ? RD_W : WR_W;

  // PWRUP_CYCLES = 0 still spends one cycle in PWRUP.
  localparam logic [PW_W-1:0] PW_LAST = PW_W'((PWRUP_CYCLES == 0) ? 0 : PWRUP_CYCLES - 1);
  localparam logic [OP_W-1:0] RD_LAST = OP_W'(RD_CYCLES - 1);
  localparam logic [OP_W-1:0] WR_LAST = OP_W'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_IDLE,
    S_WR_ACT,
    S_WR_REC,
    S_RD_ACT,
    S_RD_DONE
  } state_t;

  state_t            r_state, w_nxt;
  logic              w_accept_wr, w_accept_rd;
  logic [1:0]        w_be;
  logic [PW_W-1:0]   r_pw;
  logic [OP_W-1:0]   r_cnt;
  logic [22:0]       r_addr;
  logic [15:0]       r_wdata, r_rdata;
  logic [1:0]        r_be;
  logic              r_drive;
  logic              r_ce_n, r_oe_n, r_we_n, r_adv_n, r_ub_n, r_lb_n;
  logic              r_begun, r_fin, r_ok, r_good;

`ifdef CRAM_BYTE_MASK_EN
  // Byte enables of the write being launched, or of the one in flight.
  assign w_be = w_accept_wr ? app.app_be : r_be;
`else
  assign w_be = 2'b11;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= S_PWRUP;
    else        r_state <= w_nxt;
  end

  // Next-state decode; requests are only looked at in IDLE, write wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_nxt       = r_state;
    w_accept_wr = 1'b0;
    w_accept_rd = 1'b0;
    case (r_state)
      S_PWRUP:   if (r_pw == PW_LAST) w_nxt = S_IDLE;
      S_IDLE: begin
        if (app.app_wr) begin
          w_nxt       = S_WR_ACT;
          w_accept_wr = 1'b1;
        end else if (app.app_rd) begin
          w_nxt       = S_RD_ACT;
          w_accept_rd = 1'b1;
        end
      end
      S_WR_ACT:  if (r_cnt == '0) w_nxt = S_WR_REC;
      S_WR_REC:  w_nxt = S_IDLE;
      S_RD_ACT:  if (r_cnt == '0) w_nxt = S_RD_DONE;
      S_RD_DONE: w_nxt = S_IDLE;
      default:   w_nxt = S_PWRUP;
    endcase
  end

  // Power-up wait counter and per-access pulse-width counter (reloaded on accept).
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pw  <= '0;
      r_cnt <= '0;
    end else begin
      if (r_state == S_PWRUP) r_pw <= r_pw + PW_W'(1);
      if (w_accept_wr)        r_cnt <= WR_LAST;
      else if (w_accept_rd)   r_cnt <= RD_LAST;
      else if ((r_state == S_WR_ACT || r_state == S_RD_ACT) && r_cnt != '0)
        r_cnt <= r_cnt - OP_W'(1);
    end
  end

  // Request latches and read-data capture on the last RD_ACT edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 2'b11;
      r_rdata <= '0;
    end else begin
      if (w_accept_wr || w_accept_rd) r_addr <= app.app_addr;
      if (w_accept_wr) begin
        r_wdata <= app.app_data_in;
        r_be    <= w_be;
      end
      if (r_state == S_RD_ACT && r_cnt == '0) r_rdata <= mem_data;
    end
  end

  // Pin and handshake flops decoded from the next state, so each level lines up
  // exactly with the state it belongs to.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_adv_n <= 1'b1;
      r_ub_n  <= 1'b1;
      r_lb_n  <= 1'b1;
      r_drive <= 1'b0;
      r_begun <= 1'b0;
      r_fin   <= 1'b0;
      r_ok    <= 1'b0;
      r_good  <= 1'b0;
    end else begin
      r_ce_n  <= !(w_nxt == S_WR_ACT || w_nxt == S_RD_ACT);
      r_oe_n  <= !(w_nxt == S_RD_ACT);
      r_we_n  <= !(w_nxt == S_WR_ACT);
      r_adv_n <= (w_nxt == S_PWRUP);
      r_drive <= (w_nxt == S_WR_ACT || w_nxt == S_WR_REC);
      r_begun <= w_accept_wr || w_accept_rd;
      r_fin   <= (w_nxt == S_WR_REC || w_nxt == S_RD_DONE);
      r_ok    <= (w_nxt == S_RD_DONE);
      r_good  <= (w_nxt != S_PWRUP);
      case (w_nxt)
        S_WR_ACT, S_WR_REC: begin
          r_ub_n <= ~w_be[1];
          r_lb_n <= ~w_be[0];
        end
        S_RD_ACT: begin
          r_ub_n <= 1'b0;
          r_lb_n <= 1'b0;
        end
        default: begin
          r_ub_n <= 1'b1;
          r_lb_n <= 1'b1;
        end
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_clk   = 1'b0;
  assign mem_cre   = 1'b0;
  assign mem_ce_n  = r_ce_n;
  assign mem_oe_n  = r_oe_n;
  assign mem_we_n  = r_we_n;
  assign mem_adv_n = r_adv_n;
  assign mem_ub_n  = r_ub_n;
  assign mem_lb_n  = r_lb_n;
  assign mem_data  = r_drive ? r_wdata : 16'hzzzz;

  assign app.app_data_out   = r_rdata;
  assign app.app_data_ok    = r_ok;
  assign app.app_op_begun   = r_begun;
  assign app.op_finished    = r_fin;
  assign app.app_ctrlr_good = r_good;

endmodule

// File: tb/tb_cram_async_ctrlr.sv
// Self-checking bench for cram_async_ctrlr: directed power-up, write, read,
// collision and mid-operation reset steps plus a randomized op stream checked
// against a word-array reference memory. Builds with or without CRAM_BYTE_MASK_EN.
`timescale 1ns/1ps
module tb_cram_async_ctrlr;
  localparam int PWRUP = 16;
  localparam int NCYC  = 8;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  cram_async_ctrlr_if u_if ();

  wire [22:0] mem_addr;
  wire        mem_clk, mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n, mem_ub_n, mem_lb_n, mem_cre;
  tri  [15:0] mem_data;

  // Weak pull-ups make an undriven bus read as 16'hFFFF; write data avoids that value.
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (mem_data[g]);
  end

  cram_async_ctrlr #(.PWRUP_CYCLES(PWRUP), .RD_CYCLES(NCYC), .WR_CYCLES(NCYC)) u_dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .app      (u_if),
    .mem_addr (mem_addr),
    .mem_clk  (mem_clk),
    .mem_ce_n (mem_ce_n),
    .mem_oe_n (mem_oe_n),
    .mem_we_n (mem_we_n),
    .mem_adv_n(mem_adv_n),
    .mem_ub_n (mem_ub_n),
    .mem_lb_n (mem_lb_n),
    .mem_cre  (mem_cre),
    .mem_data (mem_data)
  );

  // PSRAM device model: 64 words, drives while CE#/OE# low, stores on WE# rise.
  logic [15:0] psram [64];
  assign mem_data = (!mem_ce_n && !mem_oe_n) ? psram[mem_addr[5:0]] : 16'hzzzz;
  always @(posedge mem_we_n) begin
    if (clr_n) begin
      if (!mem_ub_n) psram[mem_addr[5:0]][15:8] = mem_data[15:8];
      if (!mem_lb_n) psram[mem_addr[5:0]][7:0]  = mem_data[7:0];
    end
  end

  // Reference contents, updated from the issued requests only.
  logic [15:0] ref_mem [64];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ctrl_vec();
    return {mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n, mem_adv_n};
  endfunction

  // Releases clr_n and follows the whole power-up wait.
  task automatic powerup_check();
    @(negedge clk);
    clr_n = 1'b1;
    for (int c = 1; c <= PWRUP; c++) begin
      tick();
      check("pwrup_good", u_if.app_ctrlr_good, (c == PWRUP) ? 1 : 0);
      check("pwrup_ctrl", ctrl_vec(), (c == PWRUP) ? 6'h3e : 6'h3f);
      check("pwrup_bus", mem_data, 16'hFFFF);
    end
  endtask

  // One access from request to the following IDLE cycle.
  task automatic do_op(input bit is_wr, input logic [22:0] addr, input logic [15:0] data,
                       input logic [1:0] be, input bit rd_too);
    int fin_cyc, ce_lo, bad;
    logic [15:0] exp_rd;
    exp_rd  = ref_mem[addr[5:0]];
    fin_cyc = 0;
    ce_lo   = 0;
    bad     = 0;
    @(negedge clk);
    u_if.app_addr    = addr;
    u_if.app_data_in = data;
    u_if.app_wr      = is_wr;
    u_if.app_rd      = !is_wr || rd_too;
`ifdef CRAM_BYTE_MASK_EN
    u_if.app_be      = be;
`endif
    for (int c = 1; c <= 20 && fin_cyc == 0; c++) begin
      tick();
      if (c == 1) begin
        check("op_begun", u_if.app_op_begun, 1);
        check("op_addr", mem_addr, addr);
      end else begin
        bad += int'(u_if.app_op_begun);
      end
      if (c == 2) begin
        u_if.app_wr = 1'b0;
        if (!rd_too) u_if.app_rd = 1'b0;
      end
      if (c == NCYC) u_if.app_rd = 1'b0;
      if (!mem_ce_n) ce_lo++;
      if (c <= NCYC) begin
        if (is_wr)
          bad += int'((mem_we_n !== 1'b0) | (mem_oe_n !== 1'b1) | (mem_data !== data) |
                      (mem_ub_n !== ~be[1]) | (mem_lb_n !== ~be[0]));
        else
          bad += int'((mem_oe_n !== 1'b0) | (mem_we_n !== 1'b1) | (mem_ub_n !== 1'b0) |
                      (mem_lb_n !== 1'b0) | (mem_data !== exp_rd));
        bad += int'((mem_addr !== addr) | u_if.op_finished | u_if.app_data_ok);
      end
      if (u_if.op_finished === 1'b1) begin
        fin_cyc = c;
        check("fin_ctrl", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
        if (is_wr) begin
          check("wr_hold", mem_data, data);
          check("wr_ok_low", u_if.app_data_ok, 0);
        end else begin
          check("rd_ok", u_if.app_data_ok, 1);
          check("rd_data", u_if.app_data_out, exp_rd);
        end
      end
    end
    check("fin_cycle", fin_cyc, NCYC + 1);
    check("ce_low_cycles", ce_lo, NCYC);
    check("act_phase", bad, 0);
    tick();
    check("idle_fin", u_if.op_finished, 0);
    check("idle_ctrl", ctrl_vec(), 6'h3e);
    check("idle_bus", mem_data, 16'hFFFF);
    check("idle_good", u_if.app_ctrlr_good, 1);
    if (is_wr) begin
      if (be[1]) ref_mem[addr[5:0]][15:8] = data[15:8];
      if (be[0]) ref_mem[addr[5:0]][7:0]  = data[7:0];
    end
  endtask

  initial begin
    logic [1:0]  be_r;
    logic [15:0] d_r;
    for (int i = 0; i < 64; i++) begin
      psram[i]   = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    u_if.app_addr    = '0;
    u_if.app_data_in = '0;
    u_if.app_wr      = 1'b0;
    u_if.app_rd      = 1'b0;
`ifdef CRAM_BYTE_MASK_EN
    u_if.app_be      = 2'b11;
`endif

    // Reset state.
    #23;
    check("rst_ctrl", ctrl_vec(), 6'h3f);
    check("rst_misc", {mem_cre, mem_clk}, 2'b00);
    check("rst_addr", mem_addr, 0);
    check("rst_bus", mem_data, 16'hFFFF);
    check("rst_app", {u_if.app_data_ok, u_if.app_op_begun, u_if.op_finished, u_if.app_ctrlr_good}, 4'h0);
    check("rst_dout", u_if.app_data_out, 0);
    powerup_check();

    // Directed write then read-back.
    do_op(1'b1, 23'd1, 16'hBABE, 2'b11, 1'b0);
    do_op(1'b0, 23'd1, 16'h0000, 2'b11, 1'b0);

    // Write and read together: write wins, held strobes start nothing more.
    do_op(1'b1, 23'd5, 16'h1234, 2'b11, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("no_second_op", {u_if.app_op_begun, mem_ce_n}, 2'b01);
    end
    do_op(1'b0, 23'd5, 16'h0000, 2'b11, 1'b0);

    // Randomized op stream.
    for (int n = 0; n < 40; n++) begin
      d_r = 16'($urandom_range(0, 16'hFFFE));
`ifdef CRAM_BYTE_MASK_EN
      be_r = 2'($urandom);
`else
      be_r = 2'b11;
`endif
      do_op(1'($urandom), 23'($urandom_range(0, 63)), d_r, be_r, 1'b0);
    end

`ifdef CRAM_BYTE_MASK_EN
    // Upper-byte-only write, then a full-word read.
    do_op(1'b1, 23'd9, 16'hA55A, 2'b10, 1'b0);
    do_op(1'b0, 23'd9, 16'h0000, 2'b11, 1'b0);
`endif

    // Reset in the middle of a read.
    @(negedge clk);
    u_if.app_addr = 23'd1;
    u_if.app_rd   = 1'b1;
    tick();
    u_if.app_rd = 1'b0;
    tick();
    tick();
    tick();
    #2 clr_n = 1'b0;
    #1;
    check("midrst_ctrl", ctrl_vec(), 6'h3f);
    check("midrst_good", u_if.app_ctrlr_good, 0);
    check("midrst_bus", mem_data, 16'hFFFF);
    check("midrst_dout", u_if.app_data_out, 0);
    powerup_check();
    do_op(1'b1, 23'd2, 16'h0F0F, 2'b11, 1'b0);
    do_op(1'b0, 23'd2, 16'h0000, 2'b11, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Hard stop in case a wait never returns.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
